// File: rtl/btn_cmd_capture_if.sv
// Command handshake bundle between the button front end (master) and the ALU (slave).
interface btn_cmd_capture_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/btn_cmd_capture.sv
// Button synchroniser/debouncer that turns each clean press into one valid/ready command.
// Optional auto-repeat while the button is held: define AUTO_REPEAT_EN.
module btn_cmd_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_in,
  input  logic [15:0]       sw_in,
  btn_cmd_capture_if.master cmd,
  output logic              btn_level,
  output logic              press_drop
);

  typedef enum logic [0:0] {S_IDLE, S_HELD} state_t;

  logic             s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [3:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic             drop_q, drop_d;
  logic             press_evt, rpt_evt, evt, accept;

  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Rising debounced level in IDLE is the only source of a fresh press.
  always_comb begin
    state_d   = state_q;
    press_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q) begin
          press_evt = 1'b1;
          state_d   = S_HELD;
        end
      end
      S_HELD: begin
        if (!level_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_first_q, rpt_first_d;

  // rpt_cnt_q counts cycles since the last press/repeat event.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_evt     = 1'b0;
    if (press_evt) begin
      rpt_cnt_d   = 32'd1;
      rpt_first_d = 1'b1;
    end else if (state_q == S_HELD && level_q) begin
      if (rpt_cnt_q == (rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD))) begin
        rpt_evt     = 1'b1;
        rpt_cnt_d   = 32'd1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 32'd1;
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_evt = 1'b0;
`endif

  assign evt    = press_evt | rpt_evt;
  assign accept = evt && (!valid_q || cmd.cmd_ready);

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      op_d    = sw_in[3:0];
      data_d  = sw_in[15:8];
    end else if (valid_q && cmd.cmd_ready) begin
      valid_d = 1'b0;
    end
    drop_d = evt && valid_q && !cmd.cmd_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      state_q <= state_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_data  = data_q;
  assign btn_level     = level_q;
  assign press_drop    = drop_q;

  // Switches 7:4 carry nothing; repeat timing is dead without the repeat feature.
  logic unused_bits;
  assign unused_bits = ^{sw_in[7:4], REPEAT_DELAY, REPEAT_PERIOD};

endmodule

// File: tb/tb_btn_cmd_capture.sv
// Randomised and directed bench for btn_cmd_capture against a window-rule behavioural model.
module tb_btn_cmd_capture;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_in = 1'b0;
  logic [15:0] sw_in = 16'h0000;
  logic        btn_level, press_drop;

  btn_cmd_capture_if cmd_if();

  btn_cmd_capture #(
    .DEBOUNCE_CYCLES(D), .CNT_W(3), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .sw_in(sw_in),
    .cmd(cmd_if), .btn_level(btn_level), .press_drop(press_drop)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: level flips once D consecutive synchronised samples disagree with it.
  bit         smp[$];
  bit         model_live = 1'b0;
  bit         m_lvl = 1'b0, m_lvl_prev = 1'b0, m_vld = 1'b0, m_drop = 1'b0;
  logic [3:0] m_op = '0;
  logic [7:0] m_data = '0;
  int         press_t = -1;

  always @(posedge clk) begin : model
    bit evt, all_diff, s;
    int n;
    cyc++;
    if (reset) begin
      smp.delete();
      m_lvl = 0; m_lvl_prev = 0; m_vld = 0; m_drop = 0;
      m_op = '0; m_data = '0; press_t = -1;
      model_live = 1'b1;
    end else begin
      evt = 1'b0;
      if (m_lvl && !m_lvl_prev) begin
        evt = 1'b1;
        press_t = cyc;
      end else if (!m_lvl) begin
        press_t = -1;
      end else if (REPEAT_ON && press_t >= 0 && (cyc - press_t) >= RD &&
                   ((cyc - press_t - RD) % RP) == 0) begin
        evt = 1'b1;
      end
      m_drop = evt && m_vld && !cmd_if.cmd_ready;
      if (evt && (!m_vld || cmd_if.cmd_ready)) begin
        m_vld  = 1'b1;
        m_op   = sw_in[3:0];
        m_data = sw_in[15:8];
      end else if (m_vld && cmd_if.cmd_ready) begin
        m_vld = 1'b0;
      end
      smp.push_back(btn_in);
      n = smp.size();
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
        s = (n - 1 - j >= 0) ? smp[n - 1 - j] : 1'b0;
        if (s == m_lvl) all_diff = 1'b0;
      end
      m_lvl_prev = m_lvl;
      if (all_diff) m_lvl = !m_lvl;
      if (n > 32) void'(smp.pop_front());
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("btn_level", 16'(btn_level), 16'(m_lvl));
      check("cmd_valid", 16'(cmd_if.cmd_valid), 16'(m_vld));
      check("cmd_op", 16'(cmd_if.cmd_op), 16'(m_op));
      check("cmd_data", 16'(cmd_if.cmd_data), 16'(m_data));
      check("press_drop", 16'(press_drop), 16'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic v, input string nm);
    int t = 0;
    while (btn_level !== v && t < 40) begin
      tick();
      t++;
    end
    check(nm, 16'(btn_level), 16'(v));
  endtask

  initial begin
    int         base, t, nv;
    int         times[8];
    logic [8:0] glitch;
    int         len;

    cmd_if.cmd_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", 16'(cmd_if.cmd_valid), 16'h0);
    check("rst_level", 16'(btn_level), 16'h0);
    check("rst_op", 16'(cmd_if.cmd_op), 16'h0);

    // Glitchy button never settles long enough.
    glitch = 9'b0_1110_0111;
    for (int i = 0; i < 9; i++) begin
      btn_in = glitch[i];
      tick();
    end
    repeat (8) tick();
    check("glitch_level", 16'(btn_level), 16'h0);
    check("glitch_valid", 16'(cmd_if.cmd_valid), 16'h0);

    // Clean press latency and latched command.
    sw_in  = 16'hA503;
    btn_in = 1'b1;
    base   = cyc + 1;
    while (cyc < base + 4) tick();
    check("lat_level_k4", 16'(btn_level), 16'h0);
    tick();
    check("lat_level_k5", 16'(btn_level), 16'h1);
    check("lat_valid_k5", 16'(cmd_if.cmd_valid), 16'h0);
    tick();
    check("lat_valid_k6", 16'(cmd_if.cmd_valid), 16'h1);
    check("lat_op", 16'(cmd_if.cmd_op), 16'h3);
    check("lat_data", 16'(cmd_if.cmd_data), 16'hA5);

    // Second press while pending is dropped.
    btn_in = 1'b0;
    sw_in  = 16'h1F0F;
    wait_level(1'b0, "t3_release");
    btn_in = 1'b1;
    t = 0;
    while (press_drop !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check("t3_drop_seen", 16'(press_drop), 16'h1);
    check("t3_op_kept", 16'(cmd_if.cmd_op), 16'h3);
    check("t3_data_kept", 16'(cmd_if.cmd_data), 16'hA5);
    check("t3_valid_kept", 16'(cmd_if.cmd_valid), 16'h1);
    tick();
    check("t3_drop_1cyc", 16'(press_drop), 16'h0);

    // Press event coincident with the handshake reloads the command.
    btn_in = 1'b0;
    wait_level(1'b0, "t4_release");
    btn_in = 1'b1;
    wait_level(1'b1, "t4_press");
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("t4_valid", 16'(cmd_if.cmd_valid), 16'h1);
    check("t4_op", 16'(cmd_if.cmd_op), 16'hF);
    check("t4_data", 16'(cmd_if.cmd_data), 16'h1F);
    check("t4_nodrop", 16'(press_drop), 16'h0);
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("t4_cleared", 16'(cmd_if.cmd_valid), 16'h0);
    check("t4_op_hold", 16'(cmd_if.cmd_op), 16'hF);
    btn_in = 1'b0;
    wait_level(1'b0, "t4_final_release");
    repeat (2) tick();

    // Reset mid-debounce, button held through reset release.
    btn_in = 1'b1;
    base   = cyc + 1;
    while (cyc < base + 3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_level", 16'(btn_level), 16'h0);
    check("t5_valid", 16'(cmd_if.cmd_valid), 16'h0);
    check("t5_op", 16'(cmd_if.cmd_op), 16'h0);
    check("t5_data", 16'(cmd_if.cmd_data), 16'h0);
    check("t5_drop", 16'(press_drop), 16'h0);
    while (cyc < base + 10) tick();
    check("t5_valid_k10", 16'(cmd_if.cmd_valid), 16'h0);
    tick();
    check("t5_valid_k11", 16'(cmd_if.cmd_valid), 16'h1);
    check("t5_op_new", 16'(cmd_if.cmd_op), 16'hF);

    // Held button with ready high: one event, or a repeat train.
    cmd_if.cmd_ready = 1'b1;
    btn_in = 1'b0;
    wait_level(1'b0, "t6_release0");
    repeat (3) tick();
    sw_in  = 16'h3C07;
    btn_in = 1'b1;
    nv = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (cmd_if.cmd_valid === 1'b1) begin
        if (nv < 8) times[nv] = cyc;
        nv++;
      end
    end
    if (REPEAT_ON) begin
      check("t6_rep_count", 16'(nv >= 4), 16'h1);
      if (nv >= 4) begin
        check("t6_gap1", 16'(times[1] - times[0]), 16'd10);
        check("t6_gap2", 16'(times[2] - times[1]), 16'd5);
        check("t6_gap3", 16'(times[3] - times[2]), 16'd5);
      end
    end else begin
      check("t6_single", 16'(nv), 16'd1);
    end
    btn_in = 1'b0;
    wait_level(1'b0, "t6_release1");
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_if.cmd_valid === 1'b1) nv++;
    end
    check("t6_stopped", 16'(nv), 16'd0);

    // Randomised traffic.
    for (int i = 0; i < 4000; ) begin
      btn_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      for (int r = 0; r < len; r++) begin
        cmd_if.cmd_ready = ($urandom_range(0, 2) == 0);
        sw_in = 16'($urandom);
        reset = ($urandom_range(0, 599) == 0);
        tick();
        i++;
      end
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
